// File: rtl/ntm_scalar_adder_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ntm_scalar_adder_scheduler
// Description : Round-robin scheduler sharing one ntm_scalar_adder between
//               REQUESTERS clients. One addition in flight at a time; the sum
//               is returned to the granted client over a valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================
module ntm_scalar_adder_scheduler #(
    parameter int DATA_SIZE     = 8,
    parameter int REQUESTERS    = 4,
    parameter int ADDER_LATENCY = 1,
    localparam int GW           = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQUESTERS-1:0]            req_valid,
    output logic [REQUESTERS-1:0]            req_ready,
    input  logic [REQUESTERS*DATA_SIZE-1:0]  req_in1,
    input  logic [REQUESTERS*DATA_SIZE-1:0]  req_in2,
    output logic [REQUESTERS-1:0]            rsp_valid,
    input  logic [REQUESTERS-1:0]            rsp_ready,
    output logic [DATA_SIZE:0]               rsp_data,
    output logic [GW-1:0]                    grant_id,
    output logic                             busy,
    output logic [DATA_SIZE-1:0]             adder_in1,
    output logic [DATA_SIZE-1:0]             adder_in2,
    input  logic [DATA_SIZE:0]               adder_out
);

    localparam int              c_CNT_W = (ADDER_LATENCY > 0) ? $clog2(ADDER_LATENCY + 1) : 1;
    localparam logic [GW-1:0]      c_LAST  = GW'(REQUESTERS - 1);
    localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(ADDER_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t                  r_state;
    logic [GW-1:0]           r_ptr;
    logic [GW-1:0]           r_g;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [REQUESTERS-1:0]   r_rsp_valid;
    logic [DATA_SIZE:0]      r_rsp_data;
    logic [DATA_SIZE-1:0]    r_adder_in1;
    logic [DATA_SIZE-1:0]    r_adder_in2;

    logic [DATA_SIZE-1:0]    w_op1 [REQUESTERS];
    logic [DATA_SIZE-1:0]    w_op2 [REQUESTERS];
    logic                    w_found;
    logic [GW-1:0]           w_winner;
    logic [GW-1:0]           w_idx;
    int                      w_pos;
    logic                    w_handshake;
    logic [REQUESTERS-1:0]   w_g_onehot;

    // Split the packed operand buses into per-client words
    for (genvar i = 0; i < REQUESTERS; i++) begin : g_unpack
        assign w_op1[i] = req_in1[i*DATA_SIZE +: DATA_SIZE];
        assign w_op2[i] = req_in2[i*DATA_SIZE +: DATA_SIZE];
    end

    // Round-robin search: first valid client starting at the pointer
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        w_pos    = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= REQUESTERS) begin
                w_pos = w_pos - REQUESTERS;
            end
            w_idx = GW'(w_pos);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_handshake = (r_state == ST_IDLE) && w_found && !rst;

    // Accept is one-hot on the winner, only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (w_handshake) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    // One-hot decode of the granted client for the response valid
    always_comb begin
        w_g_onehot = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            w_g_onehot[i] = (r_g == GW'(i));
        end
    end

    // Scheduler FSM: grant, wait out adder latency, hold response until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_g         <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_adder_in1 <= '0;
            r_adder_in2 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_adder_in1 <= w_op1[w_winner];
                        r_adder_in2 <= w_op2[w_winner];
                        r_g         <= w_winner;
                        r_cnt       <= c_LAT;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else begin
                        // Carry bit kept as-is; no saturation
                        r_rsp_data  <= adder_out;
                        r_rsp_valid <= w_g_onehot;
                        r_state     <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    // Only the granted client's ready completes the response
                    if (rsp_ready[r_g]) begin
                        r_rsp_valid <= '0;
                        r_ptr       <= (r_g == c_LAST) ? '0 : r_g + GW'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign grant_id  = r_g;
    assign busy      = (r_state != ST_IDLE);
    assign adder_in1 = r_adder_in1;
    assign adder_in2 = r_adder_in2;

endmodule
`default_nettype wire

// File: tb/tb_ntm_scalar_adder_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntm_scalar_adder_scheduler
// Description : Directed self-checking bench for ntm_scalar_adder_scheduler
//               with a one-cycle registered adder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntm_scalar_adder_scheduler;

    localparam int DS = 8;
    localparam int NR = 4;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DS-1:0] req_in1;
    logic [NR*DS-1:0] req_in2;
    logic [NR-1:0]    rsp_valid;
    logic [NR-1:0]    rsp_ready;
    logic [DS:0]      rsp_data;
    logic [1:0]       grant_id;
    logic             busy;
    logic [DS-1:0]    adder_in1;
    logic [DS-1:0]    adder_in2;
    logic [DS:0]      adder_out;

    int n_checks = 0;
    int n_fail   = 0;

    ntm_scalar_adder_scheduler #(
        .DATA_SIZE     (DS),
        .REQUESTERS    (NR),
        .ADDER_LATENCY (1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .adder_in1 (adder_in1),
        .adder_in2 (adder_in2),
        .adder_out (adder_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered adder model, latency 1
    always @(posedge clk) begin
        adder_out <= {1'b0, adder_in1} + {1'b0, adder_in2};
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
        end
    endtask

    task automatic set_ops(input int c, input logic [7:0] a, input logic [7:0] b);
        req_in1[c*DS +: DS] = a;
        req_in2[c*DS +: DS] = b;
    endtask

    // Called just after inputs are driven in an IDLE cycle; rsp_ready[c] must
    // already be high. Returns one step into the IDLE cycle after the response.
    task automatic issue(input int c, input int sum, input int a, input int b, input bit keep);
        chk("req_ready", req_ready, 32'(1 << c));
        chk("busy_idle", busy, 0);
        @(negedge clk);
        if (!keep) req_valid[c] = 1'b0;
        chk("adder_in1", adder_in1, a);
        chk("adder_in2", adder_in2, b);
        chk("grant_id", grant_id, c);
        chk("busy_t1", busy, 1);
        chk("rsp_valid_t1", rsp_valid, 0);
        #1 chk("req_ready_wait", req_ready, 0);
        @(negedge clk);
        chk("rsp_valid_t2", rsp_valid, 0);
        chk("busy_t2", busy, 1);
        @(negedge clk);
        chk("rsp_valid_t3", rsp_valid, 32'(1 << c));
        chk("rsp_data", rsp_data, sum);
        chk("busy_t3", busy, 1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0001;
        rsp_ready = '0;
        req_in1   = '0;
        req_in2   = '0;

        // Reset values, with a request pending to show accept is gated
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_adder_in1", adder_in1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);

        // Single request: client 0, 5+2
        set_ops(0, 8'd5, 8'd2);
        req_valid = 4'b0001;
        rsp_ready = 4'b1111;
        #1 issue(0, 7, 5, 2, 1'b0);

        // Overflow plus backpressure: client 2, 255+255
        rsp_ready = '0;
        set_ops(2, 8'd255, 8'd255);
        req_valid = 4'b0100;
        #1 chk("ovf_req_ready", req_ready, 32'b0100);
        @(negedge clk);
        req_valid = '0;
        chk("ovf_grant_id", grant_id, 2);
        chk("ovf_adder_in1", adder_in1, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        chk("ovf_rsp_valid", rsp_valid, 32'b0100);
        chk("ovf_rsp_data", rsp_data, 9'h1FE);
        set_ops(0, 8'd5, 8'd2);
        set_ops(3, 8'd100, 8'd50);
        req_valid = 4'b1001;
        rsp_ready = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_req_ready", req_ready, 0);
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 32'b0100);
            chk("bp_rsp_data", rsp_data, 9'h1FE);
            chk("bp_busy", busy, 1);
        end
        rsp_ready = 4'b0100;
        @(negedge clk);
        chk("bp_released", rsp_valid, 0);

        // Round-robin skip: pointer now 3, so client 3 before client 0
        rsp_ready = 4'b1111;
        #1 issue(3, 150, 100, 50, 1'b0);
        issue(0, 7, 5, 2, 1'b0);
        req_valid = '0;

        // Fairness: pointer at 1, all valid, order 1,2,3,0,1
        for (int i = 0; i < NR; i++) set_ops(i, 8'(10 * i + 3), 8'(200 + i));
        req_valid = 4'b1111;
        #1 issue(1, 214, 13, 201, 1'b1);
        issue(2, 225, 23, 202, 1'b1);
        issue(3, 236, 33, 203, 1'b1);
        issue(0, 203, 3, 200, 1'b1);
        issue(1, 214, 13, 201, 1'b1);
        req_valid = '0;

        // Reset during WAIT aborts the operation
        rsp_ready = '0;
        req_valid = 4'b1000;
        #1 chk("rr_req_ready", req_ready, 32'b1000);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ra_rsp_valid", rsp_valid, 0);
        chk("ra_rsp_data", rsp_data, 0);
        chk("ra_adder_in1", adder_in1, 0);
        chk("ra_adder_in2", adder_in2, 0);
        chk("ra_busy", busy, 0);
        chk("ra_grant_id", grant_id, 0);
        rsp_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ra_no_rsp", rsp_valid, 0);
            chk("ra_idle", busy, 0);
        end
        set_ops(0, 8'd5, 8'd2);
        set_ops(1, 8'd13, 8'd201);
        req_valid = 4'b0011;
        #1 issue(0, 7, 5, 2, 1'b0);
        req_valid = '0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntm_scalar_adder_scheduler.md
# ntm_scalar_adder_scheduler

Round-robin scheduler that shares one `ntm_scalar_adder` instance between `REQUESTERS` clients inside the NTM scalar arithmetic layer. Each client presents an operand pair with a valid/ready handshake. The scheduler issues one addition at a time to the adder and waits out the adder latency. It then returns the `DATA_SIZE+1`-bit sum to the granted client with a second valid/ready handshake.

## Interface
- `DATA_SIZE`, 8, operand width; results are `DATA_SIZE+1` bits.
- `REQUESTERS`, 4, number of clients; must be ≥1.
- `ADDER_LATENCY`, 1, cycles from stable `adder_in*` to valid `adder_out` (0 means combinational adder).
- One clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  REQUESTERS  per-client request valid.
- `req_ready`  out  REQUESTERS  one-hot accept, combinational.
- `req_in1`  in  REQUESTERS*DATA_SIZE  packed operand 1; client i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- `req_in2`  in  REQUESTERS*DATA_SIZE  packed operand 2; same packing.
- `rsp_valid`  out  REQUESTERS  one-hot response valid, registered.
- `rsp_ready`  in  REQUESTERS  per-client response ready.
- `rsp_data`  out  DATA_SIZE+1  sum for the client flagged by `rsp_valid`.
- `grant_id`  out  max(1,$clog2(REQUESTERS))  index of the current or last granted client.
- `busy`  out  1  high in WAIT and RESPOND.
- `adder_in1`, `adder_in2`  out  DATA_SIZE  registered operands to `ntm_scalar_adder`.
- `adder_out`  in  DATA_SIZE+1  adder result.

## Operation
- FSM states: IDLE, WAIT, RESPOND. Internal state: round-robin pointer `ptr`, latency counter `cnt`, granted index `g`.
- **IDLE**
  - Winner = first set `req_valid` bit searching `ptr`, `ptr+1`, … modulo REQUESTERS.
  - `req_ready[winner]` = 1 in the same cycle; all other `req_ready` bits = 0.
  - If no request is valid, `req_ready` = 0 and the FSM stays in IDLE.
  - On handshake: latch operands into `adder_in1`/`adder_in2`, set `g` = winner, load `cnt` = ADDER_LATENCY, go to WAIT.
- **WAIT**
  - `req_ready` = 0.
  - If `cnt` ≠ 0, decrement `cnt`.
  - If `cnt` = 0, capture `adder_out` into `rsp_data` and go to RESPOND.
- **RESPOND**
  - `rsp_valid[g]` = 1; `rsp_data` is held stable.
  - On `rsp_ready[g]`: clear `rsp_valid`, set `ptr` = (g+1) mod REQUESTERS, go to IDLE.
- Arithmetic: `rsp_data` is `adder_out` unmodified; the carry bit is kept and nothing saturates.
- `adder_in*` keep their last value outside a handshake (no clearing).
- Boundary rules:
  - `rsp_ready` on a non-granted client is ignored.
  - `rsp_ready` held high before RESPOND completes the response on the first RESPOND cycle.
  - A client dropping `req_valid` before it is granted is legal; nothing is recorded.
  - Requests arriving during WAIT or RESPOND wait; no queueing beyond the clients' own valid signals.
  - `ptr` wraps from REQUESTERS-1 to 0.
  - With REQUESTERS=1 the scheduler degenerates to a sequencer for client 0.
  - Reset at any state aborts the operation: no response is issued, and any partial result is discarded.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `cnt` = 0, `g` = 0, `grant_id` = 0.
- Reset values of outputs: `rsp_valid` = 0, `rsp_data` = 0, `adder_in1` = `adder_in2` = 0, `busy` = 0, `req_ready` = 0 while `rst` is high.
- Handshake in cycle T (IDLE):
  - `adder_in*` valid from T+1.
  - WAIT occupies cycles T+1 … T+1+ADDER_LATENCY.
  - `rsp_valid` rises in cycle T+2+ADDER_LATENCY, i.e. T+3 for the default latency.
- Response accepted in cycle R: IDLE in R+1, and a new `req_ready` is possible in R+1.
- Minimum issue interval: ADDER_LATENCY+3 cycles per operation.
- `grant_id` updates in the cycle after the handshake and holds through RESPOND and the following IDLE.
- `busy` = 1 exactly in WAIT and RESPOND cycles.

## Test plan
- **Single request** (defaults): client 0 sends in1=5, in2=2, handshake at T → `adder_in1`=5 and `adder_in2`=2 at T+1; `rsp_valid`=4'b0001 with `rsp_data`=7 at T+3; `busy` high for T+1..T+3.
- **Overflow**: client 2 sends in1=255, in2=255 → `rsp_data`=9'h1FE, `rsp_valid`=4'b0100, `grant_id`=2.
- **Fairness**: all four clients valid continuously, `rsp_ready` tied high → grant order 0,1,2,3,0,… with each response `rsp_data` = that client's sum; `ptr` wraps from 3 to 0.
- **Round-robin skip**: after client 2 completes, clients 0 and 3 are valid in the same cycle → client 3 is granted first, then client 0.
- **Backpressure**: `rsp_ready[g]` held low for 5 cycles in RESPOND → `rsp_valid` and `rsp_data` are stable throughout, `req_ready` stays 0; asserting `rsp_ready` on another client has no effect.
- **Reset mid-operation**: `rst` pulsed for 1 cycle during WAIT → no `rsp_valid` afterwards, all outputs at reset values; the next simultaneous request from clients 1 and 0 grants client 0.
